// File: rtl/prim_ram_1p_initiator.sv
// Initiator-side controller for a single-port synchronous RAM. It serialises host
// reads and writes onto the RAM port, buffers read responses, and can zeroize/init the array.
module prim_ram_1p_initiator #(
  parameter int unsigned      Width       = 32,
  parameter int unsigned      Depth       = 128,
  parameter bit               InitOnReset = 1'b1,
  parameter logic [Width-1:0] InitValue   = '0,
  localparam int unsigned     Aw          = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic             we_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  input  logic             init_req_i,
  output logic             init_busy_o,
  output logic             init_done_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_e;

  localparam state_e        ResetState = InitOnReset ? INIT : IDLE;
  localparam logic [Aw-1:0] LastAddr   = Aw'(Depth - 1);

  state_e                     state_r;
  logic [Aw-1:0]              cnt_r;
  logic                       init_done_r;
  logic                       inflight_r;
  logic [1:0]                 occ_r;
  logic [1:0][Width-1:0]      buf_r;
  logic                       wr_ptr_r;
  logic                       rd_ptr_r;
  logic                       room_s;
  logic                       gnt_s;
  logic                       push_s;
  logic                       pop_s;

  // Host acceptance: a read needs a free buffer slot counting the one already in flight
  always_comb begin
    room_s = 1'b0;
    gnt_s  = 1'b0;
    room_s = (occ_r + {1'b0, inflight_r}) < 2'd2;
    if (rst_ni && (state_r == IDLE)) begin
      gnt_s = req_i & ~init_req_i & (we_i | room_s);
    end else begin
      gnt_s = 1'b0;
    end
  end

  // RAM port steering: init sweep owns the port, otherwise granted host traffic passes through
  always_comb begin
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = addr_i;
    ram_wdata_o = wdata_i;
    ram_wmask_o = wmask_i;
    if (!rst_ni) begin
      ram_req_o   = 1'b0;
      ram_write_o = 1'b0;
    end else if (state_r == INIT) begin
      ram_req_o   = 1'b1;
      ram_write_o = 1'b1;
      ram_addr_o  = cnt_r;
      ram_wdata_o = InitValue;
      ram_wmask_o = {Width{1'b1}};
    end else begin
      ram_req_o   = gnt_s;
      ram_write_o = gnt_s & we_i;
    end
  end

  // Init sequencer: walks every word once, then pulses done on the first idle cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ResetState;
      cnt_r       <= '0;
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          init_done_r <= 1'b0;
          if (init_req_i) begin
            state_r <= INIT;
            cnt_r   <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        INIT: begin
          if (cnt_r == LastAddr) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            init_done_r <= 1'b1;
          end else begin
            cnt_r       <= cnt_r + 1'b1;
            init_done_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ResetState;
          cnt_r       <= '0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Data from the RAM is only stored when it cannot flow straight out to the host
  assign push_s = inflight_r & ((occ_r != 2'd0) | ~rready_i);
  assign pop_s  = (occ_r != 2'd0) & rready_i;

  // Response buffer: two-entry FIFO plus the read-in-flight marker
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_r <= 1'b0;
      occ_r      <= 2'd0;
      buf_r      <= '0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
    end else begin
      inflight_r <= gnt_s & ~we_i;
      occ_r      <= occ_r + {1'b0, push_s} - {1'b0, pop_s};
      if (push_s) begin
        buf_r[wr_ptr_r] <= ram_rdata_i;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  // Response presentation: buffered data is older than anything in flight
  always_comb begin
    rdata_o = '0;
    if (occ_r != 2'd0) begin
      rdata_o = buf_r[rd_ptr_r];
    end else if (inflight_r) begin
      rdata_o = ram_rdata_i;
    end else begin
      rdata_o = '0;
    end
  end

  assign rvalid_o    = inflight_r | (occ_r != 2'd0);
  assign gnt_o       = gnt_s;
  assign init_busy_o = (state_r == INIT);
  assign init_done_o = init_done_r;

endmodule
